mac_acc_relu: RTL and testbench

Output stage that sits directly downstream of the MAC unit in the convolution/FC datapath. Loads a per-output bias, accumulates exactly KLEN valid MAC results into a guard-banded accumulator, then applies ReLU and saturation to 32-bit signed. It emits one result per kernel window as a single-cycle valid pulse for the pooling/writeback stage.

---
 rtl/cnn_pkg.sv | 9 +
 rtl/relu_sat.sv | 20 ++
 rtl/mac_acc_relu.sv | 65 ++++++
 tb/tb_mac_acc_relu.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared datapath width, FSM encoding and saturation limits for CNN output stages
package cnn_pkg;
  localparam int DATA_W = 32;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC = 2'd1;
  localparam logic [1:0] ST_OUT = 2'd2;
  localparam logic [DATA_W-1:0] SAT_POS = 32'h7FFF_FFFF;
  localparam logic [DATA_W-1:0] SAT_NEG = 32'h8000_0000;
endpackage

// File: rtl/relu_sat.sv
// relu_sat: optional ReLU then signed saturation of a wide accumulator to 32 bits
module relu_sat
  import cnn_pkg::*;
#(
  parameter int ACC_W = 40,
  parameter int RELU_EN = 1
) (
  input  logic [ACC_W-1:0]  i_acc,
  output logic [DATA_W-1:0] o_dout
);
  logic w_neg, w_pos_ovf, w_neg_ovf;
  always_comb begin
    w_neg = i_acc[ACC_W-1];
    w_pos_ovf = !w_neg && (|i_acc[ACC_W-2:DATA_W-1]);
    w_neg_ovf = w_neg && !(&i_acc[ACC_W-2:DATA_W-1]);
    o_dout = (RELU_EN != 0 && w_neg) ? '0 :
             w_pos_ovf ? SAT_POS :
             w_neg_ovf ? SAT_NEG : i_acc[DATA_W-1:0];
  end
endmodule

// File: rtl/mac_acc_relu.sv
// mac_acc_relu: bias-seeded KLEN-beat accumulator with ReLU/saturation and one-cycle result strobe
module mac_acc_relu
  import cnn_pkg::*;
#(
  parameter int KLEN = 25,
  parameter int ACC_W = 40,
  parameter int RELU_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic              bias_vld,
  input  logic [DATA_W-1:0] bias_din,
  input  logic              mac_din_vld,
  input  logic [DATA_W-1:0] mac_din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  output logic              busy,
  output logic              err
);
  localparam int CNT_W = (KLEN > 1) ? $clog2(KLEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KLEN - 1);
  logic [1:0]        r_state;
  logic [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_dout;
  logic              r_dout_vld, r_err;
  logic [DATA_W-1:0] w_sat;
  relu_sat #(.ACC_W(ACC_W), .RELU_EN(RELU_EN)) u_sat (.i_acc(r_acc), .o_dout(w_sat));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_acc <= '0;
      r_cnt <= '0;
      r_dout <= '0;
      r_dout_vld <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_dout_vld <= 1'b0;
      if (ce) begin
        if (r_state == ST_OUT) begin
          r_dout <= w_sat;
          r_dout_vld <= 1'b1;
        end
        // OUT accepts a new bias so back-to-back windows leave no idle gap
        if (bias_vld && r_state != ST_ACC) begin
          r_acc <= {{(ACC_W-DATA_W){bias_din[DATA_W-1]}}, bias_din};
          r_cnt <= '0;
          r_state <= ST_ACC;
        end else if (r_state == ST_OUT) begin
          r_state <= ST_IDLE;
        end else if (r_state == ST_ACC && mac_din_vld) begin
          r_acc <= r_acc + {{(ACC_W-DATA_W){mac_din[DATA_W-1]}}, mac_din};
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) r_state <= ST_OUT;
        end
        if ((mac_din_vld && r_state != ST_ACC) || (bias_vld && r_state == ST_ACC)) r_err <= 1'b1;
      end
    end
  end
  assign dout = r_dout;
  assign dout_vld = r_dout_vld;
  assign busy = (r_state != ST_IDLE);
  assign err = r_err;
endmodule

// File: tb/tb_mac_acc_relu.sv
// tb_mac_acc_relu: directed vectors on KLEN=3 instances with ReLU on and off
module tb_mac_acc_relu;
  logic clk = 1'b0;
  logic rst_n, ce, bias_vld, mac_din_vld;
  logic [31:0] bias_din, mac_din;
  logic [31:0] dout1, dout0;
  logic dv1, dv0, busy1, busy0, err1, err0;
  int n_vec = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  mac_acc_relu #(.KLEN(3), .ACC_W(40), .RELU_EN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .bias_vld(bias_vld), .bias_din(bias_din),
    .mac_din_vld(mac_din_vld), .mac_din(mac_din), .dout(dout1), .dout_vld(dv1),
    .busy(busy1), .err(err1));
  mac_acc_relu #(.KLEN(3), .ACC_W(40), .RELU_EN(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .bias_vld(bias_vld), .bias_din(bias_din),
    .mac_din_vld(mac_din_vld), .mac_din(mac_din), .dout(dout0), .dout_vld(dv0),
    .busy(busy0), .err(err0));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input logic c, input logic bv, input logic [31:0] b, input logic mv, input logic [31:0] m);
    ce = c;
    bias_vld = bv;
    bias_din = b;
    mac_din_vld = mv;
    mac_din = m;
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    step(1, 0, 0, 0, 0);
  endtask
  task automatic window(input logic [31:0] b, input logic [31:0] m0, input logic [31:0] m1, input logic [31:0] m2);
    step(1, 1, b, 0, 0);
    step(1, 0, 0, 1, m0);
    step(1, 0, 0, 1, m1);
    step(1, 0, 0, 1, m2);
  endtask
  initial begin
    rst_n = 1'b0;
    ce = 1'b0; bias_vld = 1'b0; bias_din = '0; mac_din_vld = 1'b0; mac_din = '0;
    #12 rst_n = 1'b1;
    chk("rst_dout", dout1, 0);
    chk("rst_vld", {31'b0, dv1}, 0);
    chk("rst_busy", {31'b0, busy1}, 0);
    chk("rst_err", {31'b0, err1}, 0);
    // basic window: 10+1+2+3
    step(1, 1, 10, 0, 0);
    chk("basic_busy_start", {31'b0, busy1}, 1);
    step(1, 0, 0, 1, 1);
    step(1, 0, 0, 1, 2);
    step(1, 0, 0, 1, 3);
    chk("basic_busy_out", {31'b0, busy1}, 1);
    chk("basic_no_early_vld", {31'b0, dv1}, 0);
    idle();
    chk("basic_vld", {31'b0, dv1}, 1);
    chk("basic_dout", dout1, 16);
    chk("basic_dout_norelu", dout0, 16);
    chk("basic_busy_end", {31'b0, busy1}, 0);
    idle();
    chk("basic_vld_fall", {31'b0, dv1}, 0);
    chk("basic_dout_hold", dout1, 16);
    // negative result
    window(32'hFFFF_FF9C, 1, 2, 3);
    idle();
    chk("neg_relu", dout1, 0);
    chk("neg_norelu", dout0, 32'hFFFF_FFA2);
    // saturation
    window(32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000);
    idle();
    chk("sat_pos_relu", dout1, 32'h7FFF_FFFF);
    chk("sat_pos_norelu", dout0, 32'h7FFF_FFFF);
    window(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
    idle();
    chk("sat_neg_norelu", dout0, 32'h8000_0000);
    chk("sat_neg_relu", dout1, 0);
    chk("err_clean", {31'b0, err1}, 0);
    // back-to-back: bias for B in A's OUT cycle
    window(10, 1, 2, 3);
    step(1, 1, 1, 0, 0);
    chk("b2b_vld_a", {31'b0, dv1}, 1);
    chk("b2b_dout_a", dout1, 16);
    chk("b2b_busy", {31'b0, busy1}, 1);
    step(1, 0, 0, 1, 2);
    chk("b2b_vld_gap", {31'b0, dv1}, 0);
    step(1, 0, 0, 1, 2);
    step(1, 0, 0, 1, 2);
    idle();
    chk("b2b_vld_b", {31'b0, dv1}, 1);
    chk("b2b_dout_b", dout1, 7);
    // ce=0 for 3 cycles mid-ACC, inputs ignored
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 1, 4);
    repeat (3) begin
      step(0, 1, 99, 1, 100);
      chk("ce_vld_low", {31'b0, dv1}, 0);
    end
    step(1, 0, 0, 1, 4);
    step(1, 0, 0, 1, 4);
    idle();
    chk("ce_dout", dout1, 12);
    chk("ce_vld", {31'b0, dv1}, 1);
    chk("ce_err_held", {31'b0, err1}, 0);
    // ce=0 on the OUT cycle delays the strobe
    window(0, 1, 1, 1);
    step(0, 0, 0, 0, 0);
    chk("ce_out_delay", {31'b0, dv1}, 0);
    chk("ce_out_busy", {31'b0, busy1}, 1);
    idle();
    chk("ce_out_vld", {31'b0, dv1}, 1);
    chk("ce_out_dout", dout1, 3);
    // protocol errors
    step(1, 0, 0, 1, 5);
    chk("idle_mac_err", {31'b0, err1}, 1);
    chk("idle_mac_busy", {31'b0, busy1}, 0);
    idle();
    chk("idle_mac_nostrobe", {31'b0, dv1}, 0);
    window(5, 1, 1, 1);
    idle();
    chk("after_err_dout", dout1, 8);
    step(1, 1, 5, 0, 0);
    step(1, 0, 0, 1, 1);
    step(1, 1, 100, 0, 0);
    step(1, 0, 0, 1, 1);
    step(1, 0, 0, 1, 1);
    idle();
    chk("acc_bias_ignored", dout1, 8);
    chk("acc_bias_err", {31'b0, err0}, 1);
    // async reset mid-window
    step(1, 1, 7, 0, 0);
    step(1, 0, 0, 1, 1);
    step(1, 0, 0, 1, 1);
    rst_n = 1'b0;
    #2;
    chk("arst_dout", dout1, 0);
    chk("arst_busy", {31'b0, busy1}, 0);
    chk("arst_err", {31'b0, err1}, 0);
    rst_n = 1'b1;
    idle();
    chk("arst_nostrobe", {31'b0, dv1}, 0);
    window(0, 4, 4, 4);
    idle();
    chk("arst_next_dout", dout1, 12);
    chk("arst_next_vld", {31'b0, dv1}, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
